sqrt_exponent_pipe: RTL and testbench
=====================================

// Module: sqrt_exponent_pipe
// PURPOSE
//  Pipelined, handshaked exponent stage of the square-root unit. Halves the
//  biased exponent of a single- or double-precision operand, flags the odd
//  unbiased-exponent case (mantissa must be doubled before the root), and
//  classifies special operands. Sits between operand unpack and the mantissa
//  root iterator. Supersedes the combinational exponent handler with
//  parametrised widths, subnormal/special handling and valid/ready flow control.
// PARAMETERS
//  EXP_W    11  double-precision exponent width; bias = 2^(EXP_W-1)-1
//  EXP_S_W  8   single-precision exponent width; bias = 2^(EXP_S_W-1)-1
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  in_valid   in   1        input operand valid
//  in_ready   out  1        stage can accept operand this cycle
//  type       in   1        0 = single (uses exp[EXP_S_W-1:0]), 1 = double
//  sign       in   1        operand sign
//  exp        in   EXP_W    biased exponent (upper bits ignored when type=0)
//  frac_zero  in   1        1 when operand fraction field is all zero
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_type   out  1        type carried through
//  out_sign   out  1        result sign (see BEHAVIOUR)
//  out_exp    out  EXP_W    biased result exponent, zero-extended for single
//  out_odd    out  1        1 = mantissa must be left-shifted 1 before root
//  out_class  out  3        0 normal, 1 zero, 2 inf, 3 NaN, 4 subnormal input
// BEHAVIOUR
//  - Reset (rst=0, async): both stage valids 0; every output 0; in_ready 1
//    after release.
//  - Two register stages: S1 = classify + sum, S2 = shift + output regs.
//    Latency 2 cycles from accepted input to out_valid; throughput 1/cycle.
//  - Transfer on valid&&ready. s2_adv = !s2_valid || out_ready;
//    s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. No bubbles when
//    out_ready held 1; outputs held stable while out_valid && !out_ready.
//  - B = bias for selected type, E = selected exponent field, MAX = all ones.
//  - Normal (0<E<MAX, sign=0): out_exp = (E + B) >> 1 using EXP_W+1-bit sum;
//    out_odd = ~E[0] (unbiased exponent odd); class 0.
//  - Subnormal (E=0, !frac_zero, sign=0): compute as E=1; out_odd=0; class 4
//    (mantissa normaliser downstream adjusts).
//  - Zero (E=0, frac_zero): out_exp=0, out_odd=0, out_sign=sign, class 1.
//  - +Inf (E=MAX, frac_zero, sign=0): out_exp=MAX, class 2.
//  - NaN (E=MAX, !frac_zero) or negative nonzero (sign=1, not zero):
//    out_exp=MAX, out_sign=0, out_odd=0, class 3.
//  - out_sign = 0 for all classes except zero.
//  - Reset mid-operation flushes both stages; in-flight operands discarded.
// TESTING
//  - Double, E=1023 -> out_exp=1023, odd=0, class 0; E=1024 -> 1023, odd=1;
//    E=2046 -> 1534, odd=1.
//  - Single, E=127 -> 127, odd=0; E=128 -> 127, odd=1; E=254 -> 190, odd=1;
//    exp[10:8]=3'b111 ignored.
//  - Specials: E=0/frac_zero/sign=1 -> class 1, out_sign=1; double E=2047
//    frac_zero -> class 2 exp 2047; sign=1 E=1023 -> class 3; double E=0
//    !frac_zero -> class 4, exp 512.
//  - Backpressure: 4 back-to-back inputs, out_ready=0 for 3 cycles -> in_ready
//    drops after 2 accepted, outputs stable, all 4 emerge in order, none lost.
//  - Streaming: 32 random inputs, out_ready=1 -> one result per cycle,
//    2-cycle latency, matches reference model.
//  - Assert rst=0 with both stages full -> out_valid=0 immediately, all
//    outputs 0; next input after release emerges 2 cycles later.

Source files
------------

// File: rtl/sqrt_exponent_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : sqrt_exponent_pipe
// Brief  : Two-stage valid/ready exponent stage of the square-root unit: halves
//          the biased exponent, flags odd unbiased exponents, classifies specials.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module sqrt_exponent_pipe #(
  parameter int EXP_W   = 11,
  parameter int EXP_S_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_type,
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic             frac_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_type,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_odd,
  output logic [2:0]       out_class
);

  localparam logic [2:0] c_cls_norm = 3'd0;
  localparam logic [2:0] c_cls_zero = 3'd1;
  localparam logic [2:0] c_cls_inf  = 3'd2;
  localparam logic [2:0] c_cls_nan  = 3'd3;
  localparam logic [2:0] c_cls_sub  = 3'd4;

  localparam logic [EXP_W:0]   c_bias_d = {2'b00, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W:0]   c_bias_s = {{(EXP_W-EXP_S_W+2){1'b0}}, {(EXP_S_W-1){1'b1}}};
  localparam logic [EXP_W-1:0] c_max_d  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] c_max_s  = {{(EXP_W-EXP_S_W){1'b0}}, {EXP_S_W{1'b1}}};

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             r_s1_valid;
  logic             r_s2_valid;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && rst;

  // Stage 1: field select, classification and biased sum
  logic [EXP_W-1:0] w_e;
  logic [EXP_W-1:0] w_e_eff;
  logic [EXP_W-1:0] w_max;
  logic [EXP_W:0]   w_bias;
  logic [EXP_W:0]   w_sum;
  logic             w_e_zero;
  logic             w_e_max;
  logic [2:0]       w_class;
  logic             w_sign;

  assign w_e      = in_type ? exp : {{(EXP_W-EXP_S_W){1'b0}}, exp[EXP_S_W-1:0]};
  assign w_max    = in_type ? c_max_d : c_max_s;
  assign w_bias   = in_type ? c_bias_d : c_bias_s;
  assign w_e_zero = (w_e == '0);
  assign w_e_max  = (w_e == w_max);

  always_comb begin
    w_class = c_cls_norm;
    w_sign  = 1'b0;
    w_e_eff = w_e;
    if (w_e_zero && frac_zero) begin
      w_class = c_cls_zero;
      w_sign  = sign;
    end else if ((w_e_max && !frac_zero) || sign) begin
      w_class = c_cls_nan;
    end else if (w_e_max) begin
      w_class = c_cls_inf;
    end else if (w_e_zero) begin
      w_class = c_cls_sub;
      w_e_eff = {{(EXP_W-1){1'b0}}, 1'b1};
    end
  end

  // The bias is odd, so the sum's LSB is the odd-unbiased-exponent flag
  assign w_sum = {1'b0, w_e_eff} + w_bias;

  logic             r_s1_type;
  logic             r_s1_sign;
  logic [2:0]       r_s1_class;
  logic [EXP_W:0]   r_s1_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_type  <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_class <= 3'd0;
      r_s1_sum   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_type  <= in_type;
        r_s1_sign  <= w_sign;
        r_s1_class <= w_class;
        r_s1_sum   <= w_sum;
      end
    end
  end

  // Stage 2: halve the sum and force special-operand exponents
  logic [EXP_W-1:0] w_s2_max;
  logic [EXP_W-1:0] w_s2_exp;
  logic             w_s2_odd;

  assign w_s2_max = r_s1_type ? c_max_d : c_max_s;

  always_comb begin
    w_s2_exp = r_s1_sum[EXP_W:1];
    w_s2_odd = r_s1_sum[0];
    case (r_s1_class)
      c_cls_zero: begin
        w_s2_exp = '0;
        w_s2_odd = 1'b0;
      end
      c_cls_inf, c_cls_nan: begin
        w_s2_exp = w_s2_max;
        w_s2_odd = 1'b0;
      end
      c_cls_sub: w_s2_odd = 1'b0;
      default: ;
    endcase
  end

  logic             r_out_type;
  logic             r_out_sign;
  logic [EXP_W-1:0] r_out_exp;
  logic             r_out_odd;
  logic [2:0]       r_out_class;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid  <= 1'b0;
      r_out_type  <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_odd   <= 1'b0;
      r_out_class <= 3'd0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_type  <= r_s1_type;
        r_out_sign  <= r_s1_sign;
        r_out_exp   <= w_s2_exp;
        r_out_odd   <= w_s2_odd;
        r_out_class <= r_s1_class;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_type  = r_out_type;
  assign out_sign  = r_out_sign;
  assign out_exp   = r_out_exp;
  assign out_odd   = r_out_odd;
  assign out_class = r_out_class;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_exponent_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_sqrt_exponent_pipe
// Brief  : Directed and randomised checks of sqrt_exponent_pipe.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_sqrt_exponent_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_type;
  logic        sign;
  logic [10:0] exp;
  logic        frac_zero;
  logic        out_valid;
  logic        out_ready;
  logic        out_type;
  logic        out_sign;
  logic [10:0] out_exp;
  logic        out_odd;
  logic [2:0]  out_class;
  logic [16:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sqrt_exponent_pipe #(.EXP_W(11), .EXP_S_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .sign      (sign),
    .exp       (exp),
    .frac_zero (frac_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_odd   (out_odd),
    .out_class (out_class)
  );

  assign obs = {out_type, out_sign, out_exp, out_odd, out_class};

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: {type, sign, exp, odd, class} from the unbiased exponent
  function automatic logic [16:0] model(input logic t, input logic s,
                                        input logic [10:0] e_in, input logic fz);
    int e, b, mx, u;
    logic [10:0] oe;
    logic od, os;
    logic [2:0] cl;
    e  = t ? int'(e_in) : int'(e_in[7:0]);
    b  = t ? 1023 : 127;
    mx = t ? 2047 : 255;
    os = 1'b0;
    od = 1'b0;
    if (e == 0 && fz) begin
      cl = 3'd1; oe = 11'd0; os = s;
    end else if ((e == mx && !fz) || s) begin
      cl = 3'd3; oe = 11'(mx);
    end else if (e == mx) begin
      cl = 3'd2; oe = 11'(mx);
    end else begin
      if (e == 0) begin
        cl = 3'd4; e = 1;
      end else begin
        cl = 3'd0;
      end
      u  = e - b;
      oe = 11'(b + (u - (u & 1)) / 2);
      od = (cl == 3'd0) && ((u & 1) != 0);
    end
    return {t, os, oe, od, cl};
  endfunction

  task automatic one(input string tag, input logic t, input logic s, input logic [10:0] e,
                     input logic fz, input logic [16:0] expv);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_type   = t;
    sign      = s;
    exp       = e;
    frac_zero = fz;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    #1 chk({tag, "_vld"}, out_valid, 1);
    chk(tag, obs, expv);
  endtask

  task automatic stream(input string tag, input int n, input bit bp);
    logic [13:0] items[$];
    logic [16:0] exq[$];
    int          cyq[$];
    int          idx = 0;
    int          cyc = 0;
    int          got = 0;
    logic [17:0] held = '0;
    bit          have_held = 1'b0;
    logic [13:0] it;
    for (int i = 0; i < n; i++) begin
      it[13]   = 1'($urandom_range(0, 1));
      it[12]   = ($urandom_range(0, 7) == 0);
      it[11:1] = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 5) == 0) it[11:1] = 11'd0;
      it[0]    = 1'($urandom_range(0, 1));
      items.push_back(it);
    end
    while ((idx < n || exq.size() > 0) && cyc < 200) begin
      @(negedge clk);
      out_ready = bp ? (cyc >= 5) : 1'b1;
      if (idx < n) begin
        in_valid = 1'b1;
        {in_type, sign, exp, frac_zero} = items[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (have_held) begin
        chk({tag, "_hold"}, {out_valid, obs}, held);
        have_held = 1'b0;
      end
      if (out_valid) begin
        if (exq.size() == 0) begin
          chk({tag, "_spurious"}, out_valid, 0);
        end else if (out_ready) begin
          chk({tag, "_data"}, obs, exq[0]);
          if (!bp) chk({tag, "_lat"}, cyc, cyq[0] + 2);
          void'(exq.pop_front());
          void'(cyq.pop_front());
          got++;
        end else begin
          held      = {out_valid, obs};
          have_held = 1'b1;
        end
      end
      if (bp && cyc == 2) begin
        chk({tag, "_rdy_drop"}, in_ready, 0);
        chk({tag, "_accepted"}, idx, 2);
      end
      if (in_valid && in_ready) begin
        exq.push_back(model(items[idx][13], items[idx][12], items[idx][11:1], items[idx][0]));
        cyq.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, got, n);
    if (!bp) chk({tag, "_cycles"}, cyc, n + 2);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_type   = 1'b0;
    sign      = 1'b0;
    exp       = '0;
    frac_zero = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_outs", {out_valid, obs}, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    one("d_1023",  1'b1, 1'b0, 11'd1023, 1'b0, {1'b1, 1'b0, 11'd1023, 1'b0, 3'd0});
    one("d_1024",  1'b1, 1'b0, 11'd1024, 1'b0, {1'b1, 1'b0, 11'd1023, 1'b1, 3'd0});
    one("d_2046",  1'b1, 1'b0, 11'd2046, 1'b1, {1'b1, 1'b0, 11'd1534, 1'b1, 3'd0});
    one("s_127",   1'b0, 1'b0, 11'd127,  1'b0, {1'b0, 1'b0, 11'd127,  1'b0, 3'd0});
    one("s_128",   1'b0, 1'b0, 11'd128,  1'b0, {1'b0, 1'b0, 11'd127,  1'b1, 3'd0});
    one("s_254",   1'b0, 1'b0, 11'd254,  1'b0, {1'b0, 1'b0, 11'd190,  1'b1, 3'd0});
    one("s_upper", 1'b0, 1'b0, 11'h780,  1'b0, {1'b0, 1'b0, 11'd127,  1'b1, 3'd0});
    one("d_negz",  1'b1, 1'b1, 11'd0,    1'b1, {1'b1, 1'b1, 11'd0,    1'b0, 3'd1});
    one("s_posz",  1'b0, 1'b0, 11'd0,    1'b1, {1'b0, 1'b0, 11'd0,    1'b0, 3'd1});
    one("d_inf",   1'b1, 1'b0, 11'd2047, 1'b1, {1'b1, 1'b0, 11'd2047, 1'b0, 3'd2});
    one("d_neg",   1'b1, 1'b1, 11'd1023, 1'b0, {1'b1, 1'b0, 11'd2047, 1'b0, 3'd3});
    one("s_nan",   1'b0, 1'b0, 11'd255,  1'b0, {1'b0, 1'b0, 11'd255,  1'b0, 3'd3});
    one("s_ninf",  1'b0, 1'b1, 11'd255,  1'b1, {1'b0, 1'b0, 11'd255,  1'b0, 3'd3});
    one("d_sub",   1'b1, 1'b0, 11'd0,    1'b0, {1'b1, 1'b0, 11'd512,  1'b0, 3'd4});
    one("s_sub",   1'b0, 1'b0, 11'd0,    1'b0, {1'b0, 1'b0, 11'd64,   1'b0, 3'd4});

    stream("bp", 4, 1'b1);
    stream("strm", 32, 1'b0);

    // Fill both stages under backpressure, then reset asynchronously
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    {in_type, sign, exp, frac_zero} = {1'b1, 1'b0, 11'd1500, 1'b0};
    @(negedge clk);
    {in_type, sign, exp, frac_zero} = {1'b0, 1'b0, 11'd200, 1'b0};
    #1 chk("fill_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("fill_vld", out_valid, 1);
    #2 rst = 1'b0;
    #1 chk("mid_rst_outs", {out_valid, obs}, 0);
    chk("mid_rst_rdy", in_ready, 0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    one("post_rst", 1'b1, 1'b0, 11'd1030, 1'b0, {1'b1, 1'b0, 11'd1026, 1'b1, 3'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
